// File: rtl/hsv_core_pkg.sv
// Shared hsv_core types for the branch unit: the op encoding and the retired-result layout.
package hsv_core_pkg;

    localparam int HSV_XLEN  = 32;
    localparam int HSV_TAG_W = 4;

    typedef enum logic [2:0] {
        BEQ  = 3'd0,
        BNE  = 3'd1,
        JAL  = 3'd2,
        JALR = 3'd3,
        BLT  = 3'd4,
        BGE  = 3'd5,
        BLTU = 3'd6,
        BGEU = 3'd7
    } branch_op_t;

    typedef struct packed {
        logic [HSV_TAG_W-1:0] tag;
        logic [HSV_XLEN-1:0]  link;
        logic [HSV_XLEN-1:0]  next_pc;
        logic                 mispredict;
        logic                 exc_misaligned;
    } branch_result_t;

    function automatic logic is_jump(branch_op_t op);
        return (op == JAL) || (op == JALR);
    endfunction

endpackage

// File: rtl/hsv_core_branch_unit_if.sv
// Issue-side and commit-side handshakes of the branch unit, bundled for port connection.
interface hsv_core_branch_unit_if
    import hsv_core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic             valid_i;
    logic             ready_o;
    branch_op_t       in_op;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [XLEN-1:0]  in_imm;
    logic             in_rvc;
    logic             in_pred_taken;
    logic [XLEN-1:0]  in_pred_target;
    logic [TAG_W-1:0] in_tag;

    logic             valid_o;
    logic             ready_i;
    logic [TAG_W-1:0] out_tag;
    logic [XLEN-1:0]  out_link;
    logic [XLEN-1:0]  out_next_pc;
    logic             out_mispredict;
    logic             out_exc_misaligned;

    modport slave (
        input  valid_i, in_op, in_pc, in_rs1, in_rs2, in_imm, in_rvc,
               in_pred_taken, in_pred_target, in_tag, ready_i,
        output ready_o, valid_o, out_tag, out_link, out_next_pc,
               out_mispredict, out_exc_misaligned
    );

    modport master (
        output valid_i, in_op, in_pc, in_rs1, in_rs2, in_imm, in_rvc,
               in_pred_taken, in_pred_target, in_tag, ready_i,
        input  ready_o, valid_o, out_tag, out_link, out_next_pc,
               out_mispredict, out_exc_misaligned
    );
endinterface

// File: rtl/hsv_core_branch_fifo.sv
// Result FIFO for the branch unit; read data is the registered entry at the read pointer.
module hsv_core_branch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_core,
    input  logic                   rst_core_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/hsv_core_branch_unit.sv
// Branch execution unit: resolves branches and jumps through two stages into a credit-managed
// result FIFO, with flush handshake and saturating retirement statistics.
module hsv_core_branch_unit
    import hsv_core_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int C_EXT      = 0,
    parameter int TAG_W      = 4,
    parameter int CNT_W      = 32
) (
    input  logic                    clk_core,
    input  logic                    rst_core_n,
    input  logic                    flush_req,
    output logic                    flush_ack,
    hsv_core_branch_unit_if.slave   bus,
    output logic [CNT_W-1:0]        stat_branches,
    output logic [CNT_W-1:0]        stat_mispred
);
    localparam int CNT_FW = $clog2(FIFO_DEPTH) + 1;

    // Same field order as branch_result_t, sized by this instance's parameters.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  link;
        logic [XLEN-1:0]  next_pc;
        logic             mispredict;
        logic             exc_misaligned;
    } result_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             taken;
        logic [XLEN-1:0]  target;
        logic [XLEN-1:0]  link;
        logic             pred_taken;
        logic [XLEN-1:0]  pred_target;
    } s1_t;

    logic              s1_valid_q, s1_valid_d;
    s1_t               s1_q, s1_d;
    logic              s2_valid_q, s2_valid_d;
    result_t           s2_q, s2_d;
    logic              flush_ack_q, flush_ack_d;
    logic [CNT_W-1:0]  stat_branches_q, stat_branches_d;
    logic [CNT_W-1:0]  stat_mispred_q, stat_mispred_d;

    logic              taken;
    logic              accept;
    logic              pop;
    logic              exc;
    logic [CNT_FW-1:0] fifo_count;
    logic [CNT_FW:0]   occupancy;
    result_t           fifo_rdata;

    // Credits cover everything in flight, so stage 2 always finds a free FIFO slot.
    assign occupancy   = {1'b0, fifo_count} + (CNT_FW+1)'(s1_valid_q) + (CNT_FW+1)'(s2_valid_q);
    assign bus.ready_o = !flush_req && (occupancy < (CNT_FW+1)'(FIFO_DEPTH));
    assign bus.valid_o = !flush_req && (fifo_count != '0);
    assign accept      = bus.valid_i && bus.ready_o;
    assign pop         = bus.valid_o && bus.ready_i;

    always_comb begin
        taken = 1'b0;
        if (is_jump(bus.in_op)) begin
            taken = 1'b1;
        end else begin
            case (bus.in_op)
                BEQ:     taken = (bus.in_rs1 == bus.in_rs2);
                BNE:     taken = (bus.in_rs1 != bus.in_rs2);
                BLT:     taken = ($signed(bus.in_rs1) <  $signed(bus.in_rs2));
                BGE:     taken = ($signed(bus.in_rs1) >= $signed(bus.in_rs2));
                BLTU:    taken = (bus.in_rs1 <  bus.in_rs2);
                BGEU:    taken = (bus.in_rs1 >= bus.in_rs2);
                default: taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        s1_valid_d = accept && !flush_req;
        s1_d       = s1_q;
        if (accept) begin
            s1_d.tag         = bus.in_tag;
            s1_d.taken       = taken;
            s1_d.target      = (bus.in_op == JALR) ? ((bus.in_rs1 + bus.in_imm) & ~XLEN'(1))
                                                   : (bus.in_pc + bus.in_imm);
            s1_d.link        = bus.in_pc + (bus.in_rvc ? XLEN'(2) : XLEN'(4));
            s1_d.pred_taken  = bus.in_pred_taken;
            s1_d.pred_target = bus.in_pred_target;
        end
    end

    // A misaligned target raises an exception instead of a redirect, so it never mispredicts.
    always_comb begin
        exc        = s1_q.taken && s1_q.target[1] && (C_EXT == 0);
        s2_valid_d = s1_valid_q && !flush_req;
        s2_d       = s2_q;
        if (s1_valid_q) begin
            s2_d.tag            = s1_q.tag;
            s2_d.link           = s1_q.link;
            s2_d.next_pc        = s1_q.taken ? s1_q.target : s1_q.link;
            s2_d.exc_misaligned = exc;
            s2_d.mispredict     = !exc && ((s1_q.pred_taken != s1_q.taken) ||
                                           (s1_q.taken && (s1_q.pred_target != s1_q.target)));
        end
    end

    always_comb begin
        flush_ack_d     = flush_req;
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (pop) begin
            if (stat_branches_q != '1) begin
                stat_branches_d = stat_branches_q + CNT_W'(1);
            end
            if (fifo_rdata.mispredict && (stat_mispred_q != '1)) begin
                stat_mispred_d = stat_mispred_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            s1_valid_q      <= 1'b0;
            s1_q            <= '0;
            s2_valid_q      <= 1'b0;
            s2_q            <= '0;
            flush_ack_q     <= 1'b0;
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_q            <= s1_d;
            s2_valid_q      <= s2_valid_d;
            s2_q            <= s2_d;
            flush_ack_q     <= flush_ack_d;
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    hsv_core_branch_fifo #(
        .WIDTH ($bits(result_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_core   (clk_core),
        .rst_core_n (rst_core_n),
        .push       (s2_valid_q && !flush_req),
        .wdata      (s2_q),
        .pop        (pop),
        .flush      (flush_req),
        .rdata      (fifo_rdata),
        .count      (fifo_count)
    );

    assign flush_ack              = flush_ack_q;
    assign stat_branches          = stat_branches_q;
    assign stat_mispred           = stat_mispred_q;
    assign bus.out_tag            = fifo_rdata.tag;
    assign bus.out_link           = fifo_rdata.link;
    assign bus.out_next_pc        = fifo_rdata.next_pc;
    assign bus.out_mispredict     = fifo_rdata.mispredict;
    assign bus.out_exc_misaligned = fifo_rdata.exc_misaligned;

endmodule
